// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture engine: FSM states, mode encodings,
// interrupt bit positions and the parameter-consistency check used at elaboration.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

    localparam logic MODE_DECIMATE = 1'b0;
    localparam logic MODE_SUM      = 1'b1;
    localparam logic PACK_PADDED   = 1'b0;
    localparam logic PACK_PACKED   = 1'b1;

    localparam int IRQ_DONE_BIT = 0;
    localparam int IRQ_CLIP_BIT = 1;

    // Lanes must hold a full group sum, and the lanes must tile the RAM word exactly.
    function automatic bit params_ok(input int num_ch, input int sample_w, input int lane_w,
                                     input int ram_w, input int div_w);
        return (lane_w >= sample_w + div_w) && (num_ch * lane_w == ram_w) && (ram_w % 8 == 0);
    endfunction

endpackage

// File: rtl/adc_bit_packer.sv
// Appends IN_W-bit fields LSB-first into a bit buffer and emits OUT_W-bit words.
// out_valid/out_data are combinational in the cycle the completing field arrives.
module adc_bit_packer #(
    parameter int IN_W  = 96,
    parameter int OUT_W = 128
) (
    input  logic             adc_clkinp,
    input  logic             iStateReset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush_clear,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);
    localparam int BUF_W  = IN_W + OUT_W;
    localparam int FILL_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  pk_buf_q, pk_buf_d, merged;
    logic [FILL_W-1:0] fill_q, fill_d, fill_sum;

    // fill_q stays below OUT_W, so the shifted field always fits inside the buffer.
    always_comb begin
        merged    = pk_buf_q | ({{OUT_W{1'b0}}, in_data} << fill_q);
        fill_sum  = fill_q + FILL_W'(IN_W);
        out_valid = 1'b0;
        out_data  = merged[OUT_W-1:0];
        pk_buf_d  = pk_buf_q;
        fill_d    = fill_q;
        if (flush_clear) begin
            pk_buf_d = '0;
            fill_d   = '0;
        end else if (in_valid) begin
            if (fill_sum >= FILL_W'(OUT_W)) begin
                out_valid = 1'b1;
                pk_buf_d  = merged >> OUT_W;
                fill_d    = fill_sum - FILL_W'(OUT_W);
            end else begin
                pk_buf_d  = merged;
                fill_d    = fill_sum;
            end
        end
    end

    always_ff @(posedge adc_clkinp or posedge iStateReset) begin
        if (iStateReset) begin
            pk_buf_q <= '0;
            fill_q   <= '0;
        end else begin
            pk_buf_q <= pk_buf_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/adc_capture_engine.sv
// Triggered ADC capture: decimates or sums frames per group, writes lane-padded or
// bit-packed words to the capture RAM and raises an interrupt at end of record.
module adc_capture_engine
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 12,
    parameter int LANE_W   = 16,
    parameter int RAM_W    = 128,
    parameter int ADDR_W   = 15,
    parameter int DIV_W    = 4,
    parameter int SHIFT_W  = 4
) (
    input  logic                     adc_clkinp,
    input  logic                     iStateReset,
    input  logic                     iSampleValid,
    input  logic [NUM_CH*SAMPLE_W-1:0] iSamples,
    input  logic                     iTrig,
    input  logic [ADDR_W:0]          iRecLength,
    input  logic [DIV_W-1:0]         iDivisor,
    input  logic                     iMode,
    input  logic                     iPack,
    input  logic [SHIFT_W-1:0]       iSumShift,
    input  logic                     iClearIrq,
    output logic                     otxTrigAck,
    output logic                     oWREN,
    output logic                     oCLKEN,
    output logic                     oCHIPSEL,
    output logic [RAM_W/8-1:0]       oBYTEEN,
    output logic [ADDR_W-1:0]        oWAddr,
    output logic [RAM_W-1:0]         oADCData,
    output logic [31:0]              oRcvInterrupt
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int PK_W  = NUM_CH * SAMPLE_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    if (!params_ok(NUM_CH, SAMPLE_W, LANE_W, RAM_W, DIV_W)) begin : g_bad_params
        $error("adc_capture_engine: LANE_W/RAM_W parameter constraints violated");
    end

    function automatic logic [SAMPLE_W-1:0] sat_field(input logic [LANE_W-1:0] v,
                                                       input logic [SHIFT_W-1:0] sh);
        logic [LANE_W-1:0] s;
        s = v >> sh;
        if (s > LANE_W'({SAMPLE_W{1'b1}})) return '1;
        return s[SAMPLE_W-1:0];
    endfunction

    cap_state_t        state_q, state_d;
    logic              trig_d, trig_rise, start, frame, vec_done, wr_go, word_vld;
    logic              len_clip, mode_q, pack_q, vld_p0, pk_valid;
    logic [LEN_W-1:0]  len_lat, len_q, wcnt_q;
    logic [DIV_W-1:0]  div_q, cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [RAM_W-1:0]  acc_q, acc_next, vec_p0, word, pk_data;
    logic [PK_W-1:0]   pk_fields;
    logic [1:0]        irq_q;

    assign trig_rise = iTrig & ~trig_d;
    assign start     = (state_q == ST_IDLE) && trig_rise && !iClearIrq;
    assign frame     = (state_q == ST_CAPTURE) && iSampleValid;
    assign vec_done  = frame && (cnt_q == div_q);
    assign len_clip  = iRecLength > MAX_LEN;
    assign len_lat   = len_clip ? MAX_LEN : iRecLength;

    assign otxTrigAck    = (state_q == ST_CAPTURE);
    assign oCLKEN        = (state_q == ST_CAPTURE);
    assign oCHIPSEL      = (state_q == ST_CAPTURE);
    assign oBYTEEN       = (state_q == ST_CAPTURE) ? '1 : '0;
    assign oRcvInterrupt = {30'd0, irq_q};

    always_comb begin
        acc_next = acc_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_q == '0)
                acc_next[c*LANE_W +: LANE_W] = LANE_W'(iSamples[c*SAMPLE_W +: SAMPLE_W]);
            else if (mode_q == MODE_SUM)
                acc_next[c*LANE_W +: LANE_W] = acc_q[c*LANE_W +: LANE_W]
                                             + LANE_W'(iSamples[c*SAMPLE_W +: SAMPLE_W]);
        end
    end

    // Stage p0 -> output: vec_p0 feeds either the padded word or the packer.
    always_comb begin
        pk_fields = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mode_q == MODE_DECIMATE)
                pk_fields[c*SAMPLE_W +: SAMPLE_W] = vec_p0[c*LANE_W +: SAMPLE_W];
            else
                pk_fields[c*SAMPLE_W +: SAMPLE_W] = sat_field(vec_p0[c*LANE_W +: LANE_W], shift_q);
        end
    end

    adc_bit_packer #(.IN_W(PK_W), .OUT_W(RAM_W)) u_packer (
        .adc_clkinp  (adc_clkinp),
        .iStateReset (iStateReset),
        .in_valid    (vld_p0 && (pack_q == PACK_PACKED)),
        .in_data     (pk_fields),
        .flush_clear (state_q != ST_CAPTURE),
        .out_valid   (pk_valid),
        .out_data    (pk_data)
    );

    always_comb begin
        word_vld = (pack_q == PACK_PADDED) ? vld_p0 : pk_valid;
        word     = (pack_q == PACK_PADDED) ? vec_p0 : pk_data;
        wr_go    = (state_q == ST_CAPTURE) && word_vld && (wcnt_q < len_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (len_lat == '0) ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: if (oWREN && (wcnt_q == len_q)) state_d = ST_DONE;
            ST_DONE:    if (iClearIrq) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clkinp or posedge iStateReset) begin
        if (iStateReset) begin
            state_q  <= ST_IDLE;
            trig_d   <= 1'b0;
            len_q    <= '0;
            div_q    <= '0;
            mode_q   <= 1'b0;
            pack_q   <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            vec_p0   <= '0;
            vld_p0   <= 1'b0;
            wcnt_q   <= '0;
            oWREN    <= 1'b0;
            oWAddr   <= '0;
            oADCData <= '0;
            irq_q    <= '0;
        end else begin
            state_q <= state_d;
            trig_d  <= iTrig;
            if (start) begin
                len_q   <= len_lat;
                div_q   <= iDivisor;
                mode_q  <= iMode;
                pack_q  <= iPack;
                shift_q <= iSumShift;
                wcnt_q  <= '0;
            end
            if (state_q != ST_CAPTURE) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (frame) begin
                acc_q <= acc_next;
                cnt_q <= vec_done ? '0 : cnt_q + 1'b1;
            end
            vld_p0 <= vec_done;
            if (vec_done) vec_p0 <= acc_next;
            oWREN <= wr_go;
            if (wr_go) begin
                oWAddr   <= wcnt_q[ADDR_W-1:0];
                oADCData <= word;
                wcnt_q   <= wcnt_q + 1'b1;
            end
            if (start) begin
                irq_q[IRQ_CLIP_BIT] <= len_clip;
                irq_q[IRQ_DONE_BIT] <= (len_lat == '0);
            end else if ((state_q == ST_CAPTURE) && (state_d == ST_DONE)) begin
                irq_q[IRQ_DONE_BIT] <= 1'b1;
            end else if (iClearIrq) begin
                irq_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_engine.sv
// Directed bench for adc_capture_engine: RAM writes are logged on the falling edge and
// compared against hand-derived words, addresses, latencies and interrupt states.
module tb_adc_capture_engine;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 12;
    localparam int LANE_W   = 16;
    localparam int RAM_W    = 128;
    localparam int ADDR_W   = 8;
    localparam int DIV_W    = 4;
    localparam int SHIFT_W  = 4;
    localparam int PK_W     = NUM_CH * SAMPLE_W;

    logic                   adc_clkinp = 1'b0;
    logic                   iStateReset, iSampleValid, iTrig, iMode, iPack, iClearIrq;
    logic [PK_W-1:0]        iSamples;
    logic [ADDR_W:0]        iRecLength;
    logic [DIV_W-1:0]       iDivisor;
    logic [SHIFT_W-1:0]     iSumShift;
    logic                   otxTrigAck, oWREN, oCLKEN, oCHIPSEL;
    logic [RAM_W/8-1:0]     oBYTEEN;
    logic [ADDR_W-1:0]      oWAddr;
    logic [RAM_W-1:0]       oADCData;
    logic [31:0]            oRcvInterrupt;

    adc_capture_engine #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .LANE_W(LANE_W), .RAM_W(RAM_W),
        .ADDR_W(ADDR_W), .DIV_W(DIV_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .adc_clkinp(adc_clkinp), .iStateReset(iStateReset), .iSampleValid(iSampleValid),
        .iSamples(iSamples), .iTrig(iTrig), .iRecLength(iRecLength), .iDivisor(iDivisor),
        .iMode(iMode), .iPack(iPack), .iSumShift(iSumShift), .iClearIrq(iClearIrq),
        .otxTrigAck(otxTrigAck), .oWREN(oWREN), .oCLKEN(oCLKEN), .oCHIPSEL(oCHIPSEL),
        .oBYTEEN(oBYTEEN), .oWAddr(oWAddr), .oADCData(oADCData), .oRcvInterrupt(oRcvInterrupt)
    );

    always #5 adc_clkinp = ~adc_clkinp;

    int cyc = 0;
    always @(posedge adc_clkinp) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [RAM_W-1:0] got, input logic [RAM_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int               wr_addr[$];
    logic [RAM_W-1:0] wr_data[$];
    int               wr_cyc[$];

    always @(negedge adc_clkinp) begin
        if (oWREN === 1'b1) begin
            wr_addr.push_back(int'(oWAddr));
            wr_data.push_back(oADCData);
            wr_cyc.push_back(cyc);
            chk("wr_ctl", {oCLKEN, oCHIPSEL, oBYTEEN}, {2'b11, {(RAM_W/8){1'b1}}});
        end
    end

    task automatic tick();
        @(posedge adc_clkinp);
        #1;
    endtask

    task automatic wr_clear();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic arm(input int len, input int div, input logic mode, input logic pack,
                       input int sh, input bit hold);
        iRecLength = (ADDR_W+1)'(len);
        iDivisor   = DIV_W'(div);
        iMode      = mode;
        iPack      = pack;
        iSumShift  = SHIFT_W'(sh);
        iTrig      = 1'b1;
        tick();
        if (!hold) iTrig = 1'b0;
    endtask

    task automatic send_frame(input logic [PK_W-1:0] f);
        iSamples     = f;
        iSampleValid = 1'b1;
        tick();
        iSampleValid = 1'b0;
    endtask

    task automatic clear_irq();
        iClearIrq = 1'b1;
        tick();
        iClearIrq = 1'b0;
    endtask

    function automatic logic [PK_W-1:0] mk_frame(input int base, input int step);
        logic [PK_W-1:0] f;
        for (int c = 0; c < NUM_CH; c++) f[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + c*step);
        return f;
    endfunction

    function automatic logic [RAM_W-1:0] pad_const(input logic [LANE_W-1:0] v);
        return {NUM_CH{v}};
    endfunction

    logic [4*PK_W-1:0] stream;
    logic [PK_W-1:0]   fr;
    int                f0;

    initial begin
        iStateReset = 1'b1; iSampleValid = 1'b0; iSamples = '0; iTrig = 1'b0;
        iRecLength = '0; iDivisor = '0; iMode = 1'b0; iPack = 1'b0; iSumShift = '0;
        iClearIrq = 1'b0;
        repeat (3) tick();
        chk("rst_ack", otxTrigAck, 0);
        chk("rst_wren", oWREN, 0);
        chk("rst_irq", oRcvInterrupt, 0);
        chk("rst_ram_ctl", {oCLKEN, oCHIPSEL, oBYTEEN}, 0);
        iStateReset = 1'b0;
        tick();

        // padded decimate, config changes during capture must be ignored
        wr_clear();
        arm(4, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t1_ack", otxTrigAck, 1);
        chk("t1_byteen", oBYTEEN, 16'hFFFF);
        iRecLength = 1; iDivisor = 2;
        f0 = cyc;
        for (int n = 0; n < 4; n++) send_frame(mk_frame(12'h100 + n, 0));
        repeat (4) tick();
        chk("t1_nwr", wr_addr.size(), 4);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("t1_addr%0d", n), wr_addr[n], n);
            chk($sformatf("t1_data%0d", n), wr_data[n], pad_const(16'h0100 + 16'(n)));
        end
        chk("t1_lat", wr_cyc[0] - f0, 2);
        chk("t1_irq", oRcvInterrupt, 1);
        chk("t1_done_ctl", {otxTrigAck, oCLKEN, oCHIPSEL, oBYTEEN}, 0);
        clear_irq();
        chk("t1_irq_clr", oRcvInterrupt, 0);

        // sum mode, 4 frames per vector
        wr_clear();
        arm(2, 3, 1'b1, 1'b0, 0, 1'b0);
        f0 = cyc;
        for (int n = 0; n < 8; n++) send_frame(mk_frame(12'hFFF, 0));
        repeat (4) tick();
        chk("t2_nwr", wr_addr.size(), 2);
        chk("t2_addr1", wr_addr[1], 1);
        chk("t2_data0", wr_data[0], pad_const(16'h3FFC));
        chk("t2_data1", wr_data[1], pad_const(16'h3FFC));
        chk("t2_lat", wr_cyc[1] - (f0 + 7), 2);
        chk("t2_irq", oRcvInterrupt, 1);
        clear_irq();

        // packed decimate: 4 vectors -> 3 words
        wr_clear();
        arm(3, 0, 1'b0, 1'b1, 0, 1'b0);
        f0 = cyc;
        for (int n = 0; n < 4; n++) send_frame(mk_frame(1, 1));
        repeat (4) tick();
        for (int n = 0; n < 4; n++) stream[n*PK_W +: PK_W] = mk_frame(1, 1);
        chk("t3_nwr", wr_addr.size(), 3);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("t3_addr%0d", n), wr_addr[n], n);
            chk($sformatf("t3_word%0d", n), wr_data[n], stream[n*RAM_W +: RAM_W]);
        end
        chk("t3_w0_lo", wr_data[0][11:0], 12'h001);
        chk("t3_w0_hi", wr_data[0][127:120], 8'h03);
        chk("t3_lat", wr_cyc[0] - (f0 + 1), 2);
        clear_irq();

        // packed sum with shift and saturation: fields = min((4*s)>>1, 0xFFF)
        wr_clear();
        fr = mk_frame(3, 0);
        fr[11:0] = 12'hFFF;
        fr[23:12] = 12'h101;
        arm(3, 3, 1'b1, 1'b1, 1, 1'b0);
        for (int n = 0; n < 16; n++) send_frame(fr);
        repeat (4) tick();
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < NUM_CH; c++) stream[n*PK_W + c*SAMPLE_W +: SAMPLE_W] = 12'h006;
            stream[n*PK_W +: SAMPLE_W]            = 12'hFFF;
            stream[n*PK_W + SAMPLE_W +: SAMPLE_W] = 12'h202;
        end
        chk("t3s_nwr", wr_addr.size(), 3);
        for (int n = 0; n < 3; n++)
            chk($sformatf("t3s_word%0d", n), wr_data[n], stream[n*RAM_W +: RAM_W]);
        clear_irq();

        // zero-length record
        wr_clear();
        arm(0, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_zero_irq", oRcvInterrupt, 1);
        chk("t4_zero_ack", otxTrigAck, 0);
        send_frame(mk_frame(5, 0));
        repeat (3) tick();
        chk("t4_zero_nwr", wr_addr.size(), 0);
        clear_irq();

        // over-long record is clipped to 2^ADDR_W words
        wr_clear();
        arm((1 << ADDR_W) + 5, 0, 1'b0, 1'b0, 0, 1'b0);
        for (int n = 0; n < (1 << ADDR_W) + 6; n++) send_frame(mk_frame(n & 12'hFFF, 0));
        repeat (4) tick();
        chk("t4_clip_nwr", wr_addr.size(), 1 << ADDR_W);
        chk("t4_clip_last_addr", wr_addr[wr_addr.size()-1], (1 << ADDR_W) - 1);
        chk("t4_clip_last_data", wr_data[wr_data.size()-1], pad_const(16'((1 << ADDR_W) - 1)));
        chk("t4_clip_irq", oRcvInterrupt, 3);
        clear_irq();

        // reset mid-capture with a partly filled packer, then a fresh packed capture
        wr_clear();
        arm(10, 0, 1'b0, 1'b1, 0, 1'b0);
        for (int n = 0; n < 5; n++) send_frame(mk_frame(12'hFFF, 0));
        repeat (2) tick();
        chk("t5_pre_nwr", wr_addr.size(), 3);
        iStateReset = 1'b1;
        tick();
        chk("t5_rst_out", {otxTrigAck, oWREN, oCLKEN, oRcvInterrupt}, 0);
        iStateReset = 1'b0;
        tick();
        wr_clear();
        arm(3, 0, 1'b0, 1'b1, 0, 1'b0);
        for (int n = 0; n < 4; n++) send_frame(mk_frame(12'hA00, 1));
        repeat (4) tick();
        for (int n = 0; n < 4; n++) stream[n*PK_W +: PK_W] = mk_frame(12'hA00, 1);
        chk("t5_nwr", wr_addr.size(), 3);
        chk("t5_addr0", wr_addr[0], 0);
        for (int n = 0; n < 3; n++)
            chk($sformatf("t5_word%0d", n), wr_data[n], stream[n*RAM_W +: RAM_W]);
        clear_irq();

        // trigger held high across clear, clear beats a simultaneous edge, then re-arm
        wr_clear();
        arm(1, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("t6_ack", otxTrigAck, 1);
        send_frame(mk_frame(12'h055, 0));
        repeat (3) tick();
        chk("t6_irq", oRcvInterrupt, 1);
        clear_irq();
        chk("t6_irq_clr", oRcvInterrupt, 0);
        repeat (3) tick();
        chk("t6_no_rearm", otxTrigAck, 0);
        iTrig = 1'b0;
        tick();
        iTrig = 1'b1;
        iClearIrq = 1'b1;
        tick();
        iClearIrq = 1'b0;
        chk("t6_clr_prio", otxTrigAck, 0);
        tick();
        chk("t6_still_idle", otxTrigAck, 0);
        iTrig = 1'b0;
        tick();
        wr_clear();
        iTrig = 1'b1;
        tick();
        chk("t6_rearm", otxTrigAck, 1);
        send_frame(mk_frame(12'h0AA, 0));
        repeat (3) tick();
        chk("t6_nwr", wr_addr.size(), 1);
        chk("t6_addr0", wr_addr[0], 0);
        chk("t6_data0", wr_data[0], pad_const(16'h00AA));
        iTrig = 1'b0;
        clear_irq();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_engine.md
# adc_capture_engine

Parametrised successor to the ADC capture path. Sits between the deserialised per-channel sample vector (one 12-bit word per channel per frame) and the dual-port capture RAM. After a trigger it decimates or sums samples over a programmable group length and writes either lane-padded or bit-packed words to RAM. At the end of each record it raises an interrupt.

## Interface
- NUM_CH, 8, channel count
- SAMPLE_W, 12, bits per raw sample
- LANE_W, 16, padded lane width; must satisfy LANE_W >= SAMPLE_W+DIV_W and NUM_CH*LANE_W == RAM_W
- RAM_W, 128, RAM data width
- ADDR_W, 15, RAM address width
- DIV_W, 4, group-length field width
- SHIFT_W, 4, sum-shift field width
- adc_clkinp  in  1  sole clock
- iStateReset  in  1  asynchronous, active-high reset
- iSampleValid  in  1  iSamples holds a new frame this cycle
- iSamples  in  NUM_CH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W]
- iTrig  in  1  trigger level; the rising edge is used
- iRecLength  in  ADDR_W+1  record length in RAM words
- iDivisor  in  DIV_W  group length = iDivisor+1 frames
- iMode  in  1  0 = decimate (first frame of group), 1 = sum group
- iPack  in  1  0 = lane-padded words, 1 = bit-packed words
- iSumShift  in  SHIFT_W  right shift applied to sums in packed mode
- iClearIrq  in  1  clears oRcvInterrupt, DONE -> IDLE
- otxTrigAck  out  1  capture in progress
- oWREN, oCLKEN, oCHIPSEL  out  1  RAM controls
- oBYTEEN  out  RAM_W/8  byte enables
- oWAddr  out  ADDR_W  write address
- oADCData  out  RAM_W  write data
- oRcvInterrupt  out  32  bit0 record done, bit1 length clipped; other bits 0

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE -> CAPTURE on a rising edge of iTrig.
  - At that edge, latch iRecLength, iDivisor, iMode, iPack and iSumShift. Changes to these inputs during a capture are ignored.
  - If the latched length exceeds 2^ADDR_W, clip it to 2^ADDR_W and set bit1.
  - If the latched length is 0, go directly to DONE with no writes.
- CAPTURE:
  - otxTrigAck, oCLKEN and oCHIPSEL are 1; oBYTEEN is all ones.
  - A frame counter counts valid frames 0..iDivisor.
  - Decimate mode: lane = frame at count 0, zero-extended.
  - Sum mode: lane = sum of all iDivisor+1 frames at LANE_W bits. This sum cannot overflow.
  - The vector is complete when the count reaches iDivisor.
- Padded mode: each vector becomes one RAM word, lane c at [c*LANE_W +: LANE_W].
- Packed mode:
  - Each lane contributes SAMPLE_W bits. Decimate uses the raw sample. Sum uses (sum >> iSumShift), saturated to 2^SAMPLE_W-1.
  - Fields are appended LSB-first into a bit buffer. Whenever the buffer holds at least RAM_W bits, the low RAM_W bits are emitted as a word.
  - At defaults, 4 vectors produce exactly 3 words.
- Words go to consecutive addresses from 0. The word counter is ADDR_W+1 bits.
- CAPTURE -> DONE in the cycle after the write with address length-1.
  - On entering DONE: oRcvInterrupt bit0 = 1, otxTrigAck = 0, RAM controls = 0.
  - Unwritten partial packer bits are discarded.
- DONE -> IDLE on iClearIrq. That same cycle clears oRcvInterrupt.
- Re-arming needs a fresh rising edge. If iTrig stays high through DONE and IDLE, nothing starts.
- iTrig edges during CAPTURE or DONE are ignored.
- Reset, including mid-capture: all state and outputs go to 0, state = IDLE, packer emptied, trigger edge detector primed to the current iTrig = 0.

## Timing
- Frame latency: vector-completing frame at cycle k -> oWREN and data at cycle k+2. This holds in both modes for the word that frame completes.
- oWREN is high for exactly one cycle per word. oWAddr and oADCData are valid in that cycle.
- Trigger at cycle t (iTrig high for the first time) -> otxTrigAck high at t+1. Frames with iSampleValid at t+1 or later count.
- Maximum throughput: one word per cycle, which occurs with iDivisor=0, padded mode and continuous valid.
- iClearIrq arriving together with a trigger edge: clear takes priority and the edge is lost.

## Structure
- Package adc_capture_pkg holds the state enum, mode encodings, the oRcvInterrupt bit indices, and elaboration checks on the parameter constraints.
- Sub-module adc_bit_packer:
  - Parameters IN_W and OUT_W.
  - Inputs: in_valid, in_data, flush_clear.
  - Outputs: out_valid, out_data.
  - Internal register is IN_W+OUT_W wide, plus a fill counter.

## Test plan
- Padded decimate: iDivisor=0, iRecLength=4, frames ch c = 0x100+n -> 4 writes at addresses 0..3. Word n lane c = 0x0100+n. Then bit0 set.
- Sum: iDivisor=3, iMode=1, all samples 0xFFF, iRecLength=2 -> every lane 0x3FFC in 2 words. 8 frames consumed.
- Packed: iPack=1, iDivisor=0, 4 vectors, ch c = c+1 -> 3 words. Word0[11:0]=0x001, word0[127:120] = low 8 bits of vector1 ch2 = 0x03.
- Length edge: iRecLength=0 -> no oWREN, bit0 at t+1. iRecLength=2^ADDR_W+5 -> bit1 set and the last address written is 2^ADDR_W-1.
- Reset mid-capture after 3 words, then re-trigger -> writes restart at address 0 and the packer starts empty.
- Trigger held high across iClearIrq -> no second capture until iTrig drops and rises again.
